// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
// wb_master_bridge : valid/ready core port to a Wishbone pipelined master.
//                    Responses are returned in order. Optional watchdog: WB_MASTER_BRIDGE_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module wb_master_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    ack_i,
    input  logic                    err_i,
    input  logic                    rty_i,
    input  logic                    stall_i
);

    localparam int         SEL_W   = DATA_WIDTH / 8;
    localparam logic [4:0] MAX_OUT = 5'(MAX_OUTSTANDING);

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, ABORT = 2'd2} state_t;
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic [4:0]      ab_q, ab_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} state_t;
`endif

    state_t                state_q, state_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            out_q, out_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic in_abort;
    logic issue;
    logic reply;
    logic ready;
    logic accept;

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    assign in_abort = (state_q == ABORT);
`else
    assign in_abort = 1'b0;
`endif

    assign issue  = stb_q & ~stall_i;
    // Replies with nothing in flight (or while aborting) are stray and dropped.
    assign reply  = (ack_i | err_i | rty_i) & (out_q != 4'd0) & ~in_abort;
    assign ready  = rstn_i & ~in_abort & (~stb_q | ~stall_i)
                  & (({1'b0, out_q} + {4'd0, issue}) < MAX_OUT);
    assign accept = req_valid_i & ready;

    always_comb begin
        state_d     = state_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        wdata_d     = wdata_q;
        out_d       = out_q;
        rsp_valid_d = reply;
        rsp_err_d   = reply & (err_i | rty_i);
        rsp_rdata_d = reply ? rdata_i : rsp_rdata_q;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
        ab_d        = ab_q;
        wd_d        = (issue || reply || state_q != ACTIVE) ? '0 : wd_q + 1'b1;
`endif

        if (accept) begin
            stb_d   = 1'b1;
            we_d    = req_we_i;
            addr_d  = req_addr_i;
            sel_d   = req_sel_i;
            wdata_d = req_wdata_i;
        end else if (issue) begin
            stb_d = 1'b0;
        end

        case ({issue, reply})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!stb_d && out_d == 4'd0) state_d = IDLE;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
                // Every in-flight and still-held request becomes an error pulse.
                if (wd_q == WD_LAST && !issue && !reply) begin
                    state_d = ABORT;
                    ab_d    = {1'b0, out_q} + {4'd0, stb_d};
                    stb_d   = 1'b0;
                    out_d   = 4'd0;
                end
`endif
            end
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            ABORT: begin
                if (ab_q != 5'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    ab_d        = ab_q - 5'd1;
                end
                if (ab_q <= 5'd1) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            sel_q       <= '0;
            wdata_q     <= '0;
            out_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            wd_q        <= '0;
            ab_q        <= 5'd0;
`endif
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            out_q       <= out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
            wd_q        <= wd_d;
            ab_q        <= ab_d;
`endif
        end
    end

    assign req_ready_o = ready;
    assign cyc_o       = (state_q == ACTIVE);
    assign stb_o       = stb_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign sel_o       = sel_q;
    assign wdata_o     = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// tb_wb_master_bridge : vector table, hand sequences and random traffic against
//                       a queue-based model of the bridge and a Wishbone slave.
// Revision: 1.0
// ============================================================================
module tb_wb_master_bridge;

    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int SW   = DW / 8;
    localparam int MAXO = 2;
`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [SW-1:0] req_sel_i;
    logic [DW-1:0] req_wdata_i;
    logic          rsp_valid_o, rsp_err_o;
    logic [DW-1:0] rsp_rdata_o;
    logic          cyc_o, stb_o, we_o;
    logic [AW-1:0] addr_o;
    logic [SW-1:0] sel_o;
    logic [DW-1:0] wdata_o, rdata_i;
    logic          ack_i, err_i, rty_i, stall_i;

    always #5 clk_i = ~clk_i;

    wb_master_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_sel_i(req_sel_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o), .sel_o(sel_o),
        .wdata_o(wdata_o), .rdata_i(rdata_i), .ack_i(ack_i), .err_i(err_i),
        .rty_i(rty_i), .stall_i(stall_i)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        req_t r;
        int   due;
    } pend_t;

    typedef struct {
        req_t          r;
        logic [DW-1:0] rdata;
        int            stall;
        int            dly;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    req_t  mq[$];   // waiting to be offered
    req_t  iq[$];   // accepted, not yet issued on the bus
    pend_t sq[$];   // issued, slave reply pending

    int out_m, acc_tot, rep_tot;
    int n_tests, n_fail, cyc_n, n_rsp, n_iss, n_stb;
    int sl_stall_pct, sl_dmin, sl_dmax, sl_force_stall, ms_gap_pct;
    bit sl_fixed, spur, chk_on, last_blocked;
    logic [DW-1:0] sl_rdata, last_rsp_rdata;
    logic          last_rsp_err;
    int last_acc_cyc, last_rsp_cyc;
    vec_t vecs[6];

    // Address bits [9:8] pick the slave reply: 1 = err, 2 = rty, otherwise ack.
    function automatic int kind_of(logic [AW-1:0] a);
        if (a[9:8] == 2'd1) return 1;
        if (a[9:8] == 2'd2) return 2;
        return 0;
    endfunction

    function automatic logic [DW-1:0] rd_fn(logic [AW-1:0] a);
        return 32'hA500_0000 ^ {6'd0, a, a, 6'd0};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic clear_model();
        mq.delete(); iq.delete(); sq.delete();
        out_m = 0; acc_tot = 0; rep_tot = 0;
    endtask

    task automatic step();
        bit rep, re, acc, iss, exp_rdy;
        int out_now, k;
        logic [DW-1:0] rd;
        pend_t p;
        rep = 0; re = 0; rd = '0;
        if (sl_force_stall > 0 && stb_o) begin
            stall_i = 1'b1;
            sl_force_stall--;
        end else begin
            stall_i = ($urandom_range(99) < sl_stall_pct);
        end
        ack_i = 0; err_i = 0; rty_i = 0; rdata_i = $urandom;
        if (sq.size() > 0 && sq[0].due <= cyc_n) begin
            rep = 1;
            rd  = sl_fixed ? sl_rdata : rd_fn(sq[0].r.addr);
            k   = kind_of(sq[0].r.addr);
            err_i = (k == 1); rty_i = (k == 2); ack_i = (k == 0);
            re = (k != 0);
            rdata_i = rd;
        end else if (spur) begin
            ack_i = 1'b1;
        end
        if (mq.size() > 0 && $urandom_range(99) >= ms_gap_pct) begin
            req_valid_i = 1'b1;
            req_we_i = mq[0].we; req_addr_i = mq[0].addr;
            req_sel_i = mq[0].sel; req_wdata_i = mq[0].wdata;
        end else begin
            req_valid_i = 1'b0;
            req_we_i = 1'($urandom); req_addr_i = AW'($urandom);
            req_sel_i = SW'($urandom); req_wdata_i = $urandom;
        end
        #1;
        out_now = out_m;
        iss = stb_o & ~stall_i;
        acc = req_valid_i & req_ready_o;
        last_blocked = req_valid_i & ~req_ready_o;
        if (stb_o) n_stb++;
        if (chk_on) begin
            exp_rdy = (!stb_o || !stall_i) && ((out_now + int'(iss)) < MAXO);
            check("req_ready", req_ready_o, exp_rdy);
            check("stb_o", stb_o, iq.size() > 0);
            if (stb_o && iq.size() > 0)
                check("bus_fields", {we_o, addr_o, sel_o, wdata_o},
                      {iq[0].we, iq[0].addr, iq[0].sel, iq[0].wdata});
        end
        if (iss) begin
            n_iss++;
            if (iq.size() > 0) begin
                p.r = iq.pop_front();
                p.due = cyc_n + $urandom_range(sl_dmax, sl_dmin);
                sq.push_back(p);
                out_m++;
            end
        end
        if (rep) begin
            sq.delete(0);
            out_m--;
            rep_tot++;
        end
        if (acc) begin
            iq.push_back(mq.pop_front());
            acc_tot++;
            last_acc_cyc = cyc_n;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc_n++;
        if (chk_on) begin
            check("rsp_valid", rsp_valid_o, rep);
            if (rep) begin
                check("rsp_rdata", rsp_rdata_o, rd);
                check("rsp_err", rsp_err_o, re);
            end
            check("cyc_o", cyc_o, (acc_tot - rep_tot) > 0);
        end
        if (rsp_valid_o) begin
            n_rsp++;
            last_rsp_cyc = cyc_n;
            last_rsp_rdata = rsp_rdata_o;
            last_rsp_err = rsp_err_o;
        end
    endtask

    task automatic reset_seq();
        rstn_i = 1'b0;
        req_valid_i = 0; ack_i = 0; err_i = 0; rty_i = 0; stall_i = 0;
        #1;
        check("rst_ready", req_ready_o, 0);
        check("rst_cyc_stb_we", {cyc_o, stb_o, we_o}, 0);
        check("rst_addr", addr_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_rsp", {rsp_valid_o, rsp_err_o}, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        clear_model();
        repeat (3) begin
            @(negedge clk_i);
            check("rst_hold_rsp", rsp_valid_o, 0);
            check("rst_hold_ready", req_ready_o, 0);
        end
        rstn_i = 1'b1;
    endtask

    task automatic push_rand(int n);
        req_t r;
        for (int i = 0; i < n; i++) begin
            r.we = 1'($urandom); r.addr = AW'($urandom);
            r.sel = SW'($urandom); r.wdata = $urandom;
            mq.push_back(r);
        end
    endtask

    task automatic push_read(logic [AW-1:0] a);
        req_t r;
        r.we = 1'b0; r.addr = a; r.sel = '1; r.wdata = '0;
        mq.push_back(r);
    endtask

    task automatic drain(string name, int budget);
        int k;
        k = 0;
        while ((mq.size() + iq.size() + sq.size()) > 0 && k < budget) begin
            step();
            k++;
        end
        check(name, mq.size() + iq.size() + sq.size(), 0);
        step();
        check({name, "_idle"}, cyc_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int r0, i0, s0, k, t_iss, drop, errs;
        bit saw_block;
        req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_sel_i = '0; req_wdata_i = '0;
        rdata_i = '0; ack_i = 0; err_i = 0; rty_i = 0; stall_i = 0;
        n_tests = 0; n_fail = 0; cyc_n = 0; n_rsp = 0; n_iss = 0; n_stb = 0;
        sl_stall_pct = 0; sl_dmin = 1; sl_dmax = 1; sl_force_stall = 0; ms_gap_pct = 0;
        sl_fixed = 0; spur = 0; chk_on = 1; sl_rdata = '0;
        last_acc_cyc = 0; last_rsp_cyc = 0;
        clear_model();

        vecs[0] = '{'{1'b0, 10'h005, 4'hF, 32'h0},        32'hDEADBEEF, 0, 1, 1'b0, 3};
        vecs[1] = '{'{1'b1, 10'h010, 4'b0011, 32'h12345678}, 32'h0,     3, 1, 1'b0, 6};
        vecs[2] = '{'{1'b0, 10'h105, 4'hF, 32'h0},        32'hCAFE0001, 0, 1, 1'b1, 3};
        vecs[3] = '{'{1'b0, 10'h2AA, 4'hF, 32'h0},        32'h0BADF00D, 1, 2, 1'b1, 5};
        vecs[4] = '{'{1'b1, 10'h3FF, 4'b1000, 32'hA5A5A5A5}, 32'h13572468, 2, 4, 1'b0, 8};
        vecs[5] = '{'{1'b0, 10'h000, 4'hF, 32'h0},        32'h89ABCDEF, 0, 3, 1'b0, 5};

        @(negedge clk_i);
        reset_seq();

        for (int i = 0; i < 6; i++) begin
            sl_fixed = 1; sl_rdata = vecs[i].rdata; sl_force_stall = vecs[i].stall;
            sl_stall_pct = 0; sl_dmin = vecs[i].dly; sl_dmax = vecs[i].dly; ms_gap_pct = 0;
            mq.push_back(vecs[i].r);
            r0 = n_rsp; i0 = n_iss; s0 = n_stb; k = 0;
            while (n_rsp == r0 && k < 30) begin
                step();
                k++;
            end
            check($sformatf("v%0d_latency", i), last_rsp_cyc - last_acc_cyc, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i), last_rsp_rdata, vecs[i].rdata);
            check($sformatf("v%0d_err", i), last_rsp_err, vecs[i].exp_err);
            check($sformatf("v%0d_issues", i), n_iss - i0, 1);
            check($sformatf("v%0d_stb_cycles", i), n_stb - s0, vecs[i].stall + 1);
            step(); step();
        end
        sl_fixed = 0;

        // Four back-to-back reads against a slow slave: window must fill and block.
        sl_dmin = 5; sl_dmax = 5;
        for (int i = 0; i < 4; i++) push_read(AW'(10'h020 + i));
        r0 = n_rsp; saw_block = 0; k = 0;
        while (n_rsp - r0 < 4 && k < 60) begin
            step();
            if (last_blocked) saw_block = 1;
            k++;
        end
        check("b2b_blocked", saw_block, 1);
        check("b2b_responses", n_rsp - r0, 4);
        check("b2b_cyc_drop", cyc_o, 0);
        drain("b2b_drain", 20);

        // Zero-wait slave: second issue coincides with the first ack.
        sl_dmin = 1; sl_dmax = 1;
        push_read(10'h031); push_read(10'h132);
        r0 = n_rsp;
        drain("same_cycle_drain", 20);
        check("same_cycle_responses", n_rsp - r0, 2);

        // Stray ack while idle.
        spur = 1; r0 = n_rsp;
        step(); step();
        spur = 0;
        step();
        check("spurious_no_rsp", n_rsp - r0, 0);

        // Random traffic.
        sl_stall_pct = 25; sl_dmin = 1; sl_dmax = 6; ms_gap_pct = 30;
        push_rand(200);
        drain("rand1_drain", 5000);

        // Reset in the middle of a burst.
        push_rand(20);
        repeat (10) step();
        reset_seq();
        push_rand(100);
        drain("rand2_drain", 3000);

`ifdef WB_MASTER_BRIDGE_TIMEOUT_EN
        chk_on = 0; sl_stall_pct = 0; ms_gap_pct = 0; sl_dmin = 1000; sl_dmax = 1000;
        push_read(10'h044); push_read(10'h045);
        i0 = n_iss; k = 0;
        while (n_iss - i0 < 2 && k < 20) begin
            step();
            k++;
        end
        t_iss = cyc_n - 1;
        r0 = n_rsp; drop = -1; errs = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (drop < 0 && !cyc_o) drop = cyc_n;
            if (rsp_valid_o && rsp_err_o && rsp_rdata_o == '0) errs++;
        end
        check("to_abort_window", (drop - t_iss >= TO) && (drop - t_iss <= TO + 1), 1);
        check("to_err_pulses", errs, 2);
        check("to_rsp_count", n_rsp - r0, 2);
        check("to_idle_ready", req_ready_o, 1);
        clear_model();
        chk_on = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: data bus width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10: word address width.
REQ-003 The block SHALL have parameter MAX_OUTSTANDING, default 2: maximum number of accepted-but-unacknowledged bus transactions, range 1..15.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 64: abort threshold, only used when the timeout feature is compiled in (see Configuration).
REQ-005 The block SHALL have these ports, one clock, reset asynchronous and active-low:
- clk_i  in  1  clock
- rstn_i  in  1  async active-low reset
- req_valid_i / req_ready_o  in/out  1  core request handshake
- req_we_i  in  1  write request
- req_addr_i  in  ADDR_WIDTH  word address
- req_sel_i  in  DATA_WIDTH/8  byte enables
- req_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  DATA_WIDTH  read data
- rsp_err_o  out  1  response is an error
- cyc_o, stb_o, we_o  out  1 each  Wishbone pipelined master controls
- addr_o, sel_o, wdata_o  out  ADDR_WIDTH, DATA_WIDTH/8, DATA_WIDTH  Wishbone address, select, data
- rdata_i  in  DATA_WIDTH;  ack_i, err_i, rty_i, stall_i  in  1 each  Wishbone slave replies

Function
REQ-006 A request SHALL be accepted on a cycle where req_valid_i & req_ready_o, and it SHALL be registered into the bus stage, driving stb_o=1 from the next cycle.
REQ-007 req_ready_o SHALL be 1 only when (stb_o=0 or stall_i=0) and (outstanding + accepting-this-cycle bus issue) < MAX_OUTSTANDING, and the state is not ABORT.
REQ-008 While stb_o=1 and stall_i=1, the block SHALL hold stb_o, we_o, addr_o, sel_o and wdata_o stable.
REQ-009 A bus issue SHALL occur on stb_o & !stall_i, and stb_o SHALL drop the next cycle unless a new request was accepted in the same cycle (back-to-back issue, one per cycle).
REQ-010 The outstanding counter SHALL increment on bus issue, decrement on ack_i|err_i|rty_i, and stay unchanged when both occur in the same cycle.
REQ-011 ack_i/err_i/rty_i received while outstanding=0 SHALL be ignored (no response, no counter change).
REQ-012 The block SHALL register each reply into a response one cycle later: rsp_valid_o=1, rsp_rdata_o=rdata_i (for writes, rdata_i is passed through unchecked), rsp_err_o=err_i|rty_i; rty SHALL NOT be retried.
REQ-013 The response interface SHALL have no backpressure, and responses SHALL be returned in issue order.
REQ-014 Minimum read latency SHALL be: accept at cycle t, stb_o at t+1, zero-wait slave ack at t+2, rsp_valid_o at t+3.
REQ-015 The FSM SHALL have the states IDLE (cyc_o=0, nothing pending), ACTIVE (stb_o=1 or outstanding>0) and ABORT (timeout build only).
REQ-016 The FSM SHALL go IDLE->ACTIVE on accept, and ACTIVE->IDLE when stb_o will be 0 and outstanding reaches 0 in the same cycle.
REQ-017 cyc_o SHALL equal 1 exactly in ACTIVE.

Reset
REQ-018 With rstn_i=0, the block SHALL asynchronously force: state=IDLE, outstanding=0, cyc_o=stb_o=we_o=0, addr_o/sel_o/wdata_o=0, rsp_valid_o=rsp_err_o=0, rsp_rdata_o=0, and req_ready_o=0 while in reset.
REQ-019 Reset asserted mid-transaction SHALL drop all in-flight transactions without generating responses.

Configuration
REQ-020 The macro WB_MASTER_BRIDGE_TIMEOUT_EN SHALL compile in a watchdog; without the macro, the watchdog, the ABORT state and TIMEOUT_CYCLES SHALL have no logic, and a missing reply SHALL hang in ACTIVE indefinitely.
REQ-021 With the macro defined, a watchdog counter SHALL clear on any bus issue or reply and count while in ACTIVE.
REQ-022 With the macro defined, reaching TIMEOUT_CYCLES SHALL enter ABORT and drive cyc_o=stb_o=0.
REQ-023 In ABORT, the block SHALL emit one rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 pulse per cycle for each lost transaction (outstanding plus any held unissued stb_o request), then return to IDLE.
REQ-024 In ABORT, the block SHALL ignore all replies.

Verification
REQ-025 Read to addr 0x005 with zero-wait slave, rdata_i=0xDEADBEEF -> rsp_valid_o at accept+3, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
REQ-026 stall_i held 3 cycles on write addr 0x010, sel=4'b0011 -> stb_o/addr_o/sel_o stable for 4 cycles, exactly one issue.
REQ-027 MAX_OUTSTANDING=2, slave delays ack 5 cycles, 4 back-to-back reads -> req_ready_o=0 after 2 issues, 4 responses returned in order, cyc_o drops after the last ack.
REQ-028 Issue and ack in the same cycle with outstanding=1 -> count stays 1; err_i on a read -> rsp_err_o=1; spurious ack_i in IDLE -> no rsp_valid_o.
REQ-029 With WB_MASTER_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=8, 2 reads never acked -> ABORT 8 cycles after the last issue, 2 error pulses, then IDLE; rstn_i low mid-burst -> all outputs 0 immediately, no responses.
